// File: rtl/vx_ahb_subordinate_mem.sv
// AHB-Lite subordinate backed by a word-organised local memory.
// Byte/half/word accesses, configurable wait states, two-cycle ERROR response,
// and full address/data phase pipelining (back-to-back NONSEQ with no bubbles).
module vx_ahb_subordinate_mem #(
  parameter int                        AHB_DATA_WIDTH = 32,
  parameter int                        AHB_ADDR_WIDTH = 32,
  parameter int                        DEPTH          = 256,
  parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                        WAIT_STATES    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      HSEL,
  input  logic [AHB_ADDR_WIDTH-1:0] HADDR,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [1:0]                HTRANS,
  input  logic [AHB_DATA_WIDTH-1:0] HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [AHB_DATA_WIDTH-1:0] HRDATA
);
  localparam int IDX_W = $clog2(DEPTH);
  // Counter preload; the wait state currently being served counts as one.
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                    r_state;
  logic [3:0]                r_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_write;
  logic [3:0]                r_be;
  logic                      r_hreadyout;
  logic                      r_hresp;
  logic [AHB_DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [AHB_ADDR_WIDTH-1:0] w_off;
  logic                      w_accept;
  logic                      w_err;
  logic [3:0]                w_be;
  logic                      w_unused;

  // Offset is unsigned, so addresses below BASE_ADDR wrap high and fail the range check.
  assign w_off    = HADDR - BASE_ADDR;
  // Address phase is only taken while this block is itself ready (IDLE/DATA/ERR2).
  assign w_accept = HSEL & HTRANS[1] & HREADY & r_hreadyout;
  assign w_err    = (HSIZE > 3'd2)
                  | ((HSIZE == 3'd1) & HADDR[0])
                  | ((HSIZE == 3'd2) & (|HADDR[1:0]))
                  | (|w_off[AHB_ADDR_WIDTH-1:IDX_W+2]);
  assign w_unused = ^{HTRANS[0], w_off[1:0]};

  // Little-endian byte-lane enables for the size/address being accepted.
  always_comb begin
    w_be = 4'b1111;
    case (HSIZE)
      3'd0:    w_be = 4'b0001 << HADDR[1:0];
      3'd1:    w_be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Transfer FSM with registered HREADYOUT/HRESP; ready states also sample the pipelined address phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_write     <= 1'b0;
      r_be        <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          if (w_accept) begin
            r_idx   <= w_off[IDX_W+1:2];
            r_write <= HWRITE;
            r_be    <= w_be;
            if (w_err) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              r_state     <= S_WAIT;
              r_cnt       <= WS_LOAD;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
            end else begin
              r_state     <= S_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Write commits at the edge ending its data phase; a reset mid-transfer never reaches DATA.
  always_ff @(posedge clk) begin
    if (r_state == S_DATA && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Read data is driven straight from the array, so a read right after a write sees the new word.
  assign HRDATA    = (r_state == S_DATA && !r_write) ? r_mem[r_idx] : '0;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

endmodule

// File: tb/tb_vx_ahb_subordinate_mem.sv
// Scoreboard bench: two instances (0 and 3 wait states) share the manager bus.
// The driver pushes expected responses from a byte-array model; a monitor pops on completion.
module tb_vx_ahb_subordinate_mem;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       hsel   = '0;
  logic [31:0]      haddr  = '0;
  logic             hwrite = 1'b0;
  logic [2:0]       hsize  = '0;
  logic [1:0]       htrans = '0;
  logic [31:0]      hwdata = '0;
  logic [1:0]       ro, rs;
  logic [1:0][31:0] rd;

  vx_ahb_subordinate_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .HSEL(hsel[0]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(ro[0]),
    .HREADYOUT(ro[0]), .HRESP(rs[0]), .HRDATA(rd[0]));

  vx_ahb_subordinate_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .HSEL(hsel[1]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(ro[1]),
    .HREADYOUT(ro[1]), .HRESP(rs[1]), .HRDATA(rd[1]));

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
    int          waits;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [7:0] mdl [2][DEPTH*4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Reference rules: size limit, natural alignment, window [BASE, BASE+DEPTH*4).
  function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] off;
    off = a - BASE;
    if (sz > 3'd2) return 1'b1;
    if ((a % (32'd1 << sz)) != 0) return 1'b1;
    if (off >= 32'(DEPTH*4)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rd_model(input int t, input logic [31:0] a);
    int b;
    b = int'((a - BASE) % 32'(DEPTH*4)) & ~3;
    return {mdl[t][b+3], mdl[t][b+2], mdl[t][b+1], mdl[t][b]};
  endfunction

  task automatic wr_model(input int t, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int p;
    int lane;
    for (int k = 0; k < (1 << sz); k++) begin
      p    = int'(a - BASE) + k;
      lane = int'((a + 32'(k)) % 4);
      mdl[t][p] = 8'(wd >> (8*lane));
    end
  endtask

  // Waits for the edge that accepts the current address phase of target tgt.
  task automatic drive_wait(input int tgt);
    bit r;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      r = ro[tgt];
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 100);
    if (!r) begin
      total++;
      bad++;
      $display("FAIL timeout dut%0d: ready stuck at %b, wanted 1", tgt, r);
    end
  endtask

  task automatic xfer(input int tgt, input bit sel, input logic [1:0] tr, input logic [31:0] a,
                      input bit w, input logic [2:0] sz, input logic [31:0] wd, input bit track = 1'b1);
    exp_t e;
    hsel      = '0;
    hsel[tgt] = sel;
    htrans    = tr;
    haddr     = a;
    hwrite    = w;
    hsize     = sz;
    if (sel && tr[1] && track) begin
      e.err   = is_err(a, sz);
      e.rd    = !w;
      e.waits = e.err ? 1 : (tgt == 1 ? 3 : 0);
      e.data  = rd_model(tgt, a);
      if (!e.err && w) wr_model(tgt, a, sz, wd);
      if (tgt == 0) q0.push_back(e); else q1.push_back(e);
    end
    drive_wait(tgt);
    hwdata = wd;
  endtask

  task automatic idle(input int tgt);
    xfer(tgt, 1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
  endtask

  // Monitor: tracks data phases per instance and checks each completion against the queue.
  bit   indata [2];
  int   lowc   [2];
  exp_t me;
  always @(negedge clk) begin
    if (!reset) begin
      indata = '{1'b0, 1'b0};
      lowc   = '{0, 0};
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (indata[d]) begin
          if (ro[d]) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
              total++;
              bad++;
              $display("FAIL dut%0d completion: got a response, expected none queued", d);
            end else begin
              me = (d == 0) ? q0.pop_front() : q1.pop_front();
              chk($sformatf("dut%0d hresp", d), 32'(rs[d]), 32'(me.err));
              chk($sformatf("dut%0d wait cycles", d), lowc[d], me.waits);
              chk($sformatf("dut%0d hrdata", d), rd[d], (me.rd && !me.err) ? me.data : 32'h0);
            end
            indata[d] = 1'b0;
          end else begin
            lowc[d]++;
            if (d == 0 && q0.size() > 0) chk("dut0 low-cycle hresp", 32'(rs[0]), 32'(q0[0].err));
            if (d == 1 && q1.size() > 0) chk("dut1 low-cycle hresp", 32'(rs[1]), 32'(q1[0].err));
            chk($sformatf("dut%0d low-cycle hrdata", d), rd[d], 32'h0);
          end
        end else begin
          chk($sformatf("dut%0d idle outputs", d), {ro[d], rs[d], rd[d][29:0]}, {1'b1, 1'b0, 30'h0});
        end
        if (ro[d] && hsel[d] && htrans[1]) begin
          indata[d] = 1'b1;
          lowc[d]   = 0;
        end
      end
    end
  end

  initial begin
    int          c0;
    logic [31:0] a;
    logic [2:0]  sz;

    #3 reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk($sformatf("dut%0d reset outputs", d), {ro[d], rs[d], rd[d][29:0]}, {1'b1, 1'b0, 30'h0});
    @(posedge clk);
    #1 reset = 1'b1;

    // Fill both memories so every model byte is known.
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < DEPTH; i++) xfer(t, 1'b1, 2'b10, 32'(i*4), 1'b1, 3'd2, $urandom);
      idle(t);
    end

    // Write then pipelined read, no waits.
    xfer(0, 1'b1, 2'b10, 32'h40, 1'b1, 3'd2, 32'hDEAD_BEEF);
    xfer(0, 1'b1, 2'b10, 32'h40, 1'b0, 3'd2, 32'h0);
    idle(0);

    // 16 writes + 16 reads back to back: one cycle per transfer.
    c0 = cyc;
    for (int i = 0; i < 16; i++) xfer(0, 1'b1, (i == 0) ? 2'b10 : 2'b11, 32'h100 + 32'(i*4), 1'b1, 3'd2, 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 16; i++) xfer(0, 1'b1, 2'b10, 32'h100 + 32'(i*4), 1'b0, 3'd2, 32'h0);
    chk("burst cycle count", 32'(cyc - c0), 32'd32);
    idle(0);

    // Wait-state instance: second transfer is held off until ready returns.
    xfer(1, 1'b1, 2'b10, 32'h40, 1'b0, 3'd2, 32'h0);
    xfer(1, 1'b1, 2'b10, 32'h44, 1'b0, 3'd2, 32'h0);
    idle(1);

    // Byte lanes.
    xfer(0, 1'b1, 2'b10, 32'h200, 1'b1, 3'd2, 32'h1122_3344);
    xfer(0, 1'b1, 2'b10, 32'h201, 1'b1, 3'd0, 32'h0000_AA00);
    xfer(0, 1'b1, 2'b10, 32'h202, 1'b1, 3'd1, 32'h5566_0000);
    xfer(0, 1'b1, 2'b10, 32'h200, 1'b0, 3'd2, 32'h0);
    idle(0);

    // Error responses, then read-back showing memory untouched.
    xfer(0, 1'b1, 2'b10, BASE + 32'(DEPTH*4), 1'b0, 3'd2, 32'h0);
    xfer(0, 1'b1, 2'b10, 32'h202, 1'b1, 3'd2, 32'hFFFF_FFFF);
    xfer(0, 1'b1, 2'b10, 32'h208, 1'b1, 3'd3, 32'h1234_5678);
    xfer(0, 1'b1, 2'b10, 32'h200, 1'b0, 3'd2, 32'h0);
    xfer(0, 1'b1, 2'b10, 32'h208, 1'b0, 3'd2, 32'h0);
    idle(0);

    // Reset during the wait of a write: outputs return immediately, write is lost.
    xfer(1, 1'b1, 2'b10, 32'h10, 1'b1, 3'd2, 32'hCAFE_0010);
    idle(1);
    xfer(1, 1'b1, 2'b10, 32'h10, 1'b1, 3'd2, 32'h5555_AAAA, 1'b0);
    hsel = '0;
    htrans = 2'b00;
    #2 reset = 1'b0;
    #1;
    chk("reset mid-wait hreadyout", 32'(ro[1]), 32'd1);
    chk("reset mid-wait hresp", 32'(rs[1]), 32'd0);
    chk("reset mid-wait hrdata", rd[1], 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    xfer(1, 1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'h0);
    idle(1);

    // Randomized mix: sizes, alignment, range, HTRANS kinds, HSEL.
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 150; i++) begin
        sz = ($urandom % 8 == 0) ? 3'd3 : 3'($urandom % 3);
        case ($urandom % 16)
          0:       a = $urandom;
          1:       a = 32'hFFFF_FFFC;
          default: a = BASE + ($urandom % 32'(DEPTH*4));
        endcase
        if (sz < 3'd3 && ($urandom % 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
        xfer(t, ($urandom % 8) != 0, 2'($urandom), a, 1'($urandom), sz, $urandom);
      end
      idle(t);
    end

    idle(0);
    idle(1);
    chk("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_ahb_subordinate_mem.md
Name: vx_ahb_subordinate_mem

Overview:
AHB-Lite subordinate with a word-organised local memory, answering manager-side transfers such as the Vortex-to-AHB adapter's 16-beat single-word sequences. It serves as the bench and system target for that path. It supports byte, halfword and word accesses, a configurable number of wait states per transfer, and the two-cycle ERROR response. It fully supports address/data phase pipelining, so back-to-back NONSEQ transfers run without bubbles.

Parameters:
AHB_DATA_WIDTH, 32, HWDATA/HRDATA width; only 32 is supported.
AHB_ADDR_WIDTH, 32, HADDR width.
DEPTH, 256, number of 32-bit words in local memory; must be a power of 2.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4 aligned.
WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY transfer (0..15).

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
HSEL  in  1  subordinate select
HADDR  in  AHB_ADDR_WIDTH  byte address (address phase)
HWRITE  in  1  1=write
HSIZE  in  3  transfer size: 0=byte, 1=half, 2=word
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWDATA  in  AHB_DATA_WIDTH  write data (data phase)
HREADY  in  1  bus-level ready; address phase is sampled only when high
HREADYOUT  out  1  subordinate ready
HRESP  out  1  0=OKAY, 1=ERROR
HRDATA  out  AHB_DATA_WIDTH  read data

Behaviour:
- Reset (reset low, async): HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter=0. Memory array is not reset. Any in-flight write is discarded.
- Address-phase accept: HSEL & HTRANS[1] & HREADY at a rising edge. The block latches addr, write, size and the error check result. IDLE/BUSY transfers and unselected slots are accepted as no-ops, answered zero-wait OKAY.
- Error check, performed at accept:
  - HSIZE > 2;
  - misaligned: size 1 with addr[0]=1, or size 2 with addr[1:0]!=0;
  - (HADDR - BASE_ADDR) >= DEPTH*4, computed unsigned; addresses below BASE_ADDR wrap and fail.
- State machine:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Accepted bad transfer -> ERR1.
    - Accepted good transfer with WAIT_STATES>0 -> WAIT (counter loaded with WAIT_STATES-1).
    - Accepted good transfer with WAIT_STATES=0 -> DATA.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 0 -> DATA. Address inputs are ignored, because HREADY is low.
  - DATA: HREADYOUT=1, HRESP=0. This is the completion cycle.
    - Write: HWDATA lanes are committed at the ending edge.
    - Read: HRDATA = mem[word] this cycle.
    - Next state is decided by the pipelined address phase sampled in the same cycle, as from IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No memory access. The next address phase is sampled here as from IDLE; a manager that cancels by driving IDLE is honoured.
- Byte lanes, little-endian:
  - byte: lane addr[1:0];
  - half: lanes {addr[1],0} and {addr[1],1};
  - word: all four lanes.
  - Unselected bytes of the memory word are unchanged. Reads always return the full word; the manager extracts the lanes.
- HRDATA is 0 in every cycle except a read DATA cycle.
- Read-after-write to the same word in consecutive transfers returns the new data: the write commits at the edge ending its data phase, and the read's data phase starts after that edge. No forwarding is needed.
- Word index = (HADDR - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
- Latency per OKAY transfer: WAIT_STATES+1 data-phase cycles. ERROR transfers always take 2 cycles. Sustained throughput is 1 transfer per (WAIT_STATES+1) cycles.
- HSEL deasserted while a data phase is pending does not abort that data phase.

Test Plan:
- WAIT_STATES=0: write 32'hDEAD_BEEF @0x40, then pipelined read @0x40 -> read DATA cycle returns 32'hDEAD_BEEF, HREADYOUT stays 1 throughout, HRESP=0.
- 16 back-to-back NONSEQ word writes 0x100..0x13C, then 16 reads, data i*32'h0101_0101 -> all match, and no bubble cycles with WAIT_STATES=0.
- WAIT_STATES=3: single read -> exactly 3 cycles HREADYOUT=0, then 1 cycle HREADYOUT=1 with data. A second transfer presented during the wait cycles is ignored until HREADY=1.
- Word 0x200 = 32'h1122_3344; byte write 8'hAA @0x201; half write 16'h5566 @0x202 -> read returns 32'h5566_AA44.
- Each of the following gives HRESP=1 with HREADYOUT 0 then 1, and leaves memory unchanged: read @BASE+DEPTH*4; word write @0x202; HSIZE=3'b011.
- Reset asserted during WAIT of a write @0x10 -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; the subsequent read @0x10 returns the pre-write value.
